dma_cmd_arbiter: RTL and testbench
==================================

# dma_cmd_arbiter

Shares the single DMA engine of `tpu_top` between two command sources: the host-side DMA pins (requester 0) and the UART command decoder (requester 1). Accepts one command at a time with round-robin fairness, drives the engine's start/parameter inputs, and tracks busy/done. Returns a per-requester completion pulse with an error flag. Sits between the requesters and the DMA engine inside `tpu_top`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit counted from `dma_start`; active only with `DMA_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  2  command valid, one bit per requester; held until accepted.
- `req_ready`  out  2  command accepted this cycle (one-hot or zero).
- `req_cmd`  in  54  two packed 27-bit commands; requester *i* uses bits [27i+26:27i] = {dir[26], ub_addr[25:18], length[17:2], elem_sz[1:0]}.
- `hold`  in  1  blocks new grants; an in-flight command still completes.
- `dma_start`  out  1  one-cycle start pulse to the engine.
- `dma_dir`, `dma_ub_addr`, `dma_length`, `dma_elem_sz`  out  1/8/16/2  registered command fields; stable from `dma_start` until completion.
- `dma_busy`  in  1  engine busy (status only; sequencing uses `dma_done`).
- `dma_done`  in  1  engine completion pulse.
- `cmpl_valid`  out  2  one-cycle completion pulse to the owning requester.
- `cmpl_err`  out  1  valid with `cmpl_valid`; 1 = timeout abort.
- `arb_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, RUN, CMPL.
- IDLE: when `hold`=0 and any `req_valid` is set, grant one requester. Round-robin: favour the requester other than `last_grant`. On grant, assert `req_ready[g]`, latch its fields and owner, set `last_grant`=g. If the latched length≠0, go to ISSUE. If length=0, go to CMPL with err=0, and `dma_start` is never asserted.
- ISSUE: `dma_start`=1 for exactly one cycle; clear the watchdog counter; go to RUN.
- RUN: wait for `dma_done`, then go to CMPL with err=0. A `dma_done` seen in any other state is ignored.
- CMPL: `cmpl_valid[owner]`=1 and `cmpl_err`=err for one cycle; go to IDLE.
- `hold` is sampled only in IDLE.
- `req_valid` dropping in a non-IDLE state has no effect on the in-flight command.
- Reset values:
  - state=IDLE; `last_grant`=1, so requester 0 wins the first tie.
  - All outputs 0, including the `dma_*` fields, `req_ready`, `cmpl_valid`, `cmpl_err` and `arb_busy`.
- Reset mid-operation aborts immediately with no completion pulse. The DMA engine shares `rst`.

## Timing
- Accept in cycle N (`req_valid[g]`&`req_ready[g]`): `dma_start` high in N+1, with fields valid from N+1.
- `dma_done` sampled in cycle M: `cmpl_valid` in M+1; earliest next `req_ready` in M+2.
- `dma_done` in N+2 (the first RUN cycle) is legal: `cmpl_valid` in N+3.
- Zero-length command accepted in N: `cmpl_valid` in N+1.
- Back-to-back throughput: one command per (engine latency + 3) cycles.
- Watchdog: counter increments every RUN cycle. When it reaches `TIMEOUT_CYCLES` without `dma_done`, go to CMPL with err=1. If `dma_done` and the limit hit coincide, `dma_done` wins (err=0).

## Configuration
- `DMA_ARB_TIMEOUT_EN` defined: watchdog counter (width clog2(`TIMEOUT_CYCLES`+1)) and timeout path are present.
- Not defined: no counter; RUN waits indefinitely for `dma_done`; `cmpl_err` is tied 0.

## Test plan
- Single request: `req_valid`=2'b01, cmd {dir=0, addr=0x10, len=4, sz=1}.
  - Required: `req_ready`=01 at N; `dma_start` at N+1 with `dma_ub_addr`=0x10, `dma_length`=4.
  - Engine `dma_done` at N+6 → `cmpl_valid`=01 at N+7, `cmpl_err`=0.
- Fairness: both requesters held valid with len=2 each, engine done 3 cycles after start.
  - Required: grant order 0,1,0,1 over 4 commands; each `req_ready` exactly one cycle.
- Hold: `hold`=1 with both valid for 20 cycles → no `req_ready`, no `dma_start`.
  - Drop `hold` → grant within 1 cycle.
  - Raise `hold` during RUN → current command still completes.
- Zero length: requester 1 sends len=0 → `cmpl_valid`=10 the next cycle; `dma_start` never pulses.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): engine never signals done → `cmpl_valid` at start+17 with `cmpl_err`=1, arbiter returns to IDLE. With the macro off, the arbiter stays in RUN for 100 cycles.
- Reset mid-RUN: assert `rst` for 1 cycle → `arb_busy`, `dma_*`, `cmpl_valid` are 0 immediately with no completion pulse. The next request wins as requester 0 on a tie.

Source files
------------

// File: rtl/dma_cmd_arbiter.sv
// dma_cmd_arbiter: shares one DMA engine between two command sources.
// Round-robin grant, one command in flight, per-requester completion pulse.
// Optional watchdog: define DMA_ARB_TIMEOUT_EN to abort a command whose engine
// never reports done within TIMEOUT_CYCLES RUN cycles (cmpl_err=1).
module dma_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [53:0] req_cmd,
    input  logic        hold,
    output logic        dma_start,
    output logic        dma_dir,
    output logic [7:0]  dma_ub_addr,
    output logic [15:0] dma_length,
    output logic [1:0]  dma_elem_sz,
    input  logic        dma_busy,
    input  logic        dma_done,
    output logic [1:0]  cmpl_valid,
    output logic        cmpl_err,
    output logic        arb_busy
);

    localparam int unsigned CMD_W = 27;

    typedef struct packed {
        logic        dir;
        logic [7:0]  ub_addr;
        logic [15:0] length;
        logic [1:0]  elem_sz;
    } dma_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_CMPL
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        owner_q;
    logic        dma_start_q;
    logic        dma_dir_q;
    logic [7:0]  dma_ub_addr_q;
    logic [15:0] dma_length_q;
    logic [1:0]  dma_elem_sz_q;
    logic [1:0]  cmpl_valid_q;
    logic        cmpl_err_q;
    logic        arb_busy_q;

    logic        gnt_any_c;
    logic        gnt_c;
    dma_cmd_t    sel_cmd_c;

    // Engine status is informational only; sequencing relies on dma_done.
    logic unused_ok;
    assign unused_ok = ^{dma_busy, 32'(TIMEOUT_CYCLES)};

    // Grant decision: only in IDLE without hold; a tie favours the requester not served last.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_c     = 1'b0;
        if (state_q == S_IDLE && !hold) begin
            gnt_any_c = |req_valid;
            if (req_valid[0] && req_valid[1]) begin
                gnt_c = ~last_grant_q;
            end else begin
                gnt_c = req_valid[1];
            end
        end
    end

    assign sel_cmd_c = dma_cmd_t'(gnt_c ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0]);
    assign req_ready = gnt_any_c ? {gnt_c, ~gnt_c} : 2'b00;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdog_q;
    logic [CNT_W-1:0] wdog_d;

    // Watchdog next value: counts RUN cycles since the start pulse.
    assign wdog_d = wdog_q + CNT_W'(1);
`endif

    // Arbiter FSM with registered engine command, completion and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            dma_start_q   <= 1'b0;
            dma_dir_q     <= 1'b0;
            dma_ub_addr_q <= 8'd0;
            dma_length_q  <= 16'd0;
            dma_elem_sz_q <= 2'd0;
            cmpl_valid_q  <= 2'b00;
            cmpl_err_q    <= 1'b0;
            arb_busy_q    <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
            wdog_q        <= '0;
`endif
        end else begin
            dma_start_q  <= 1'b0;
            cmpl_valid_q <= 2'b00;
            cmpl_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_any_c) begin
                        owner_q       <= gnt_c;
                        last_grant_q  <= gnt_c;
                        dma_dir_q     <= sel_cmd_c.dir;
                        dma_ub_addr_q <= sel_cmd_c.ub_addr;
                        dma_length_q  <= sel_cmd_c.length;
                        dma_elem_sz_q <= sel_cmd_c.elem_sz;
                        arb_busy_q    <= 1'b1;
                        if (sel_cmd_c.length != 16'd0) begin
                            state_q     <= S_ISSUE;
                            dma_start_q <= 1'b1;
                        end else begin
                            // Nothing to move: complete without touching the engine.
                            state_q      <= S_CMPL;
                            cmpl_valid_q <= {gnt_c, ~gnt_c};
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_RUN;
`ifdef DMA_ARB_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                S_RUN: begin
                    if (dma_done) begin
                        state_q      <= S_CMPL;
                        cmpl_valid_q <= {owner_q, ~owner_q};
                    end
`ifdef DMA_ARB_TIMEOUT_EN
                    else if (wdog_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_q      <= S_CMPL;
                        cmpl_valid_q <= {owner_q, ~owner_q};
                        cmpl_err_q   <= 1'b1;
                    end
                    wdog_q <= wdog_d;
`endif
                end
                S_CMPL: begin
                    state_q    <= S_IDLE;
                    arb_busy_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign dma_start   = dma_start_q;
    assign dma_dir     = dma_dir_q;
    assign dma_ub_addr = dma_ub_addr_q;
    assign dma_length  = dma_length_q;
    assign dma_elem_sz = dma_elem_sz_q;
    assign cmpl_valid  = cmpl_valid_q;
    assign arb_busy    = arb_busy_q;
`ifdef DMA_ARB_TIMEOUT_EN
    assign cmpl_err    = cmpl_err_q;
`else
    assign cmpl_err    = 1'b0;
    logic unused_err;
    assign unused_err  = cmpl_err_q;
`endif

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Directed self-checking bench for dma_cmd_arbiter (TIMEOUT_CYCLES=16).
module tb_dma_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [53:0] req_cmd;
    logic        hold;
    logic        dma_start;
    logic        dma_dir;
    logic [7:0]  dma_ub_addr;
    logic [15:0] dma_length;
    logic [1:0]  dma_elem_sz;
    logic        dma_busy;
    logic        dma_done;
    logic [1:0]  cmpl_valid;
    logic        cmpl_err;
    logic        arb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    dma_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .hold        (hold),
        .dma_start   (dma_start),
        .dma_dir     (dma_dir),
        .dma_ub_addr (dma_ub_addr),
        .dma_length  (dma_length),
        .dma_elem_sz (dma_elem_sz),
        .dma_busy    (dma_busy),
        .dma_done    (dma_done),
        .cmpl_valid  (cmpl_valid),
        .cmpl_err    (cmpl_err),
        .arb_busy    (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [26:0] mk_cmd(input logic dir, input logic [7:0] addr,
                                           input logic [15:0] len, input logic [1:0] sz);
        return {dir, addr, len, sz};
    endfunction

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int done_at;
        int ph;
        int exp_g;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_cmd   = '0;
        hold      = 1'b0;
        dma_busy  = 1'b0;
        dma_done  = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check_eq("rst_busy",   32'(arb_busy),    0);
        check_eq("rst_start",  32'(dma_start),   0);
        check_eq("rst_len",    32'(dma_length),  0);
        check_eq("rst_addr",   32'(dma_ub_addr), 0);
        check_eq("rst_cmpl",   32'(cmpl_valid),  0);
        check_eq("rst_err",    32'(cmpl_err),    0);
        check_eq("rst_ready",  32'(req_ready),   0);
        @(negedge clk);
        rst = 1'b0;

        // Fairness: both valid, len=2, engine done 3 cycles after start -> period 6
        req_cmd = {mk_cmd(1'b1, 8'h22, 16'd2, 2'd0), mk_cmd(1'b0, 8'h11, 16'd2, 2'd0)};
        done_at = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            req_valid = 2'b11;
            dma_done  = (c == done_at);
            #1;
            ph    = c % 6;
            exp_g = (c / 6) % 2;
            check_eq("fair_ready", 32'(req_ready),  (ph == 0) ? (exp_g == 1 ? 2 : 1) : 0);
            check_eq("fair_start", 32'(dma_start),  (ph == 1) ? 1 : 0);
            check_eq("fair_cmpl",  32'(cmpl_valid), (ph == 5) ? (exp_g == 1 ? 2 : 1) : 0);
            if (ph == 1) check_eq("fair_addr", 32'(dma_ub_addr), (exp_g == 1) ? 32'h22 : 32'h11);
            if (dma_start) done_at = c + 3;
        end
        @(negedge clk);
        req_valid = 2'b00;
        dma_done  = 1'b0;
        #1;
        check_eq("fair_idle", 32'(arb_busy), 0);

        // Single request from requester 0
        @(negedge clk);
        req_cmd   = {mk_cmd(1'b1, 8'h33, 16'd7, 2'd2), mk_cmd(1'b0, 8'h10, 16'd4, 2'd1)};
        req_valid = 2'b01;
        #1;
        check_eq("single_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("single_start", 32'(dma_start),   1);
        check_eq("single_addr",  32'(dma_ub_addr), 32'h10);
        check_eq("single_len",   32'(dma_length),  4);
        check_eq("single_sz",    32'(dma_elem_sz), 1);
        check_eq("single_dir",   32'(dma_dir),     0);
        check_eq("single_busy",  32'(arb_busy),    1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            req_cmd = {mk_cmd(1'b1, 8'hEE, 16'd9, 2'd3), mk_cmd(1'b1, 8'hEE, 16'd9, 2'd3)};
            #1;
            check_eq("single_start_once", 32'(dma_start),   0);
            check_eq("single_hold_addr",  32'(dma_ub_addr), 32'h10);
            check_eq("single_no_cmpl",    32'(cmpl_valid),  0);
        end
        @(negedge clk);
        dma_done = 1'b1;
        #1;
        check_eq("single_cmpl_early", 32'(cmpl_valid), 0);
        @(negedge clk);
        dma_done = 1'b0;
        #1;
        check_eq("single_cmpl", 32'(cmpl_valid), 1);
        check_eq("single_err",  32'(cmpl_err),   0);
        @(negedge clk); #1;
        check_eq("single_cmpl_once", 32'(cmpl_valid), 0);
        check_eq("single_idle",      32'(arb_busy),   0);

        // Hold blocks grants for 20 cycles
        req_cmd = {mk_cmd(1'b1, 8'h44, 16'd2, 2'd0), mk_cmd(1'b0, 8'h40, 16'd2, 2'd0)};
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            hold      = 1'b1;
            req_valid = 2'b11;
            #1;
            check_eq("hold_ready", 32'(req_ready), 0);
            check_eq("hold_start", 32'(dma_start), 0);
        end
        // Release: last grant was requester 0, so requester 1 wins the tie
        @(negedge clk);
        hold = 1'b0;
        #1;
        check_eq("hold_release_ready", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("hold_start_after", 32'(dma_start),   1);
        check_eq("hold_addr",        32'(dma_ub_addr), 32'h44);
        @(negedge clk);
        hold = 1'b1;
        #1;
        check_eq("hold_run_busy", 32'(arb_busy), 1);
        @(negedge clk);
        dma_done = 1'b1;
        #1;
        @(negedge clk);
        dma_done = 1'b0;
        #1;
        check_eq("hold_run_cmpl", 32'(cmpl_valid), 2);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check_eq("hold_again_ready", 32'(req_ready), 0);
        check_eq("hold_again_busy",  32'(arb_busy),  0);
        @(negedge clk);
        hold      = 1'b0;
        req_valid = 2'b00;

        // Zero-length from requester 1 (tie-free): no engine start
        @(negedge clk);
        req_cmd   = {mk_cmd(1'b0, 8'h99, 16'd0, 2'd1), mk_cmd(1'b0, 8'h40, 16'd2, 2'd0)};
        req_valid = 2'b10;
        #1;
        check_eq("zero_ready", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("zero_cmpl",  32'(cmpl_valid), 2);
        check_eq("zero_err",   32'(cmpl_err),   0);
        check_eq("zero_start", 32'(dma_start),  0);
        @(negedge clk); #1;
        check_eq("zero_cmpl_once", 32'(cmpl_valid), 0);
        check_eq("zero_start2",    32'(dma_start),  0);
        check_eq("zero_idle",      32'(arb_busy),   0);

        // Engine never completes
        @(negedge clk);
        req_cmd   = {mk_cmd(1'b0, 8'h00, 16'd1, 2'd0), mk_cmd(1'b1, 8'h70, 16'd5, 2'd2)};
        req_valid = 2'b01;
        #1;
        check_eq("to_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("to_start", 32'(dma_start), 1);
`ifdef DMA_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #1;
            check_eq("to_wait_cmpl", 32'(cmpl_valid), 0);
            check_eq("to_wait_busy", 32'(arb_busy),   1);
        end
        @(negedge clk); #1;
        check_eq("to_cmpl", 32'(cmpl_valid), 1);
        check_eq("to_err",  32'(cmpl_err),   1);
        @(negedge clk); #1;
        check_eq("to_idle",     32'(arb_busy),   0);
        check_eq("to_cmpl_end", 32'(cmpl_valid), 0);
        check_eq("to_err_end",  32'(cmpl_err),   0);
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk); #1;
            check_eq("norun_cmpl", 32'(cmpl_valid), 0);
            check_eq("norun_busy", 32'(arb_busy),   1);
        end
        @(negedge clk);
        dma_done = 1'b1;
        #1;
        @(negedge clk);
        dma_done = 1'b0;
        #1;
        check_eq("norun_cmpl_end", 32'(cmpl_valid), 1);
        check_eq("norun_err",      32'(cmpl_err),   0);
        @(negedge clk); #1;
        check_eq("norun_idle", 32'(arb_busy), 0);
`endif

        // Reset mid-RUN: last grant is requester 0 going in
        @(negedge clk);
        req_cmd   = {mk_cmd(1'b1, 8'h66, 16'd8, 2'd1), mk_cmd(1'b0, 8'h55, 16'd3, 2'd3)};
        req_valid = 2'b01;
        #1;
        check_eq("mid_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("mid_start", 32'(dma_start), 1);
        @(negedge clk); #1;
        check_eq("mid_run_busy", 32'(arb_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy",  32'(arb_busy),    0);
        check_eq("mid_rst_start", 32'(dma_start),   0);
        check_eq("mid_rst_len",   32'(dma_length),  0);
        check_eq("mid_rst_addr",  32'(dma_ub_addr), 0);
        check_eq("mid_rst_sz",    32'(dma_elem_sz), 0);
        check_eq("mid_rst_cmpl",  32'(cmpl_valid),  0);
        @(negedge clk);
        rst      = 1'b0;
        dma_done = 1'b1;
        #1;
        check_eq("mid_stray_ready", 32'(req_ready), 0);
        @(negedge clk);
        dma_done = 1'b0;
        #1;
        check_eq("mid_no_cmpl", 32'(cmpl_valid), 0);
        check_eq("mid_idle",    32'(arb_busy),   0);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check_eq("mid_tie_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("mid_tie_start", 32'(dma_start),   1);
        check_eq("mid_tie_addr",  32'(dma_ub_addr), 32'h55);
        check_eq("mid_tie_len",   32'(dma_length),  3);
        @(negedge clk);
        dma_done = 1'b1;
        #1;
        @(negedge clk);
        dma_done = 1'b0;
        #1;
        check_eq("mid_tie_cmpl", 32'(cmpl_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
